// File: rtl/haze_pkg.sv
// Shared definitions for the haze-removal pipeline: pixel type and default image geometry.
package haze_pkg;

  localparam int PIX_W     = 8;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef logic [PIX_W-1:0] pix_t;

  // Address width for a table of n entries, never narrower than one bit.
  function automatic int addrBits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_ram.sv
// Single-port line memory: one read and one write per cycle at the same address.
// The read returns the contents from before this cycle's write.
module line_ram
  import haze_pkg::*;
#(
  parameter int DEPTH = DEF_IMG_W,
  parameter int WIDTH = PIX_W,
  localparam int AW   = addrBits(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // The read is combinational, so it always sees the pre-write contents.
  assign rdata = mem[addr];

endmodule

// File: rtl/line_buffer3.sv
// Three-row vertical window generator: emits (row-2, row-1, row) pixels for each
// accepted pixel once two full rows of the current frame have been stored.
module line_buffer3
  import haze_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  localparam int CW    = addrBits(IMG_W),
  localparam int RW    = addrBits(IMG_H)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              Enable,
  input  logic [DATA_W-1:0] pixel_in,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic              out_valid,
  output logic [CW-1:0]     out_col,
  output logic [RW-1:0]     out_row,
  output logic              frame_done
);

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb0Data;
  logic [DATA_W-1:0] lb1Data;
  logic              accept;
  logic              lastCol;
  logic              lastRow;

  // A pixel arriving together with reset is dropped, including its memory write.
  assign accept  = Enable && !reset;
  assign lastCol = (col == CW'(IMG_W - 1));
  assign lastRow = (row == RW'(IMG_H - 1));

  line_ram #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) lb0 (
    .clock (clock),
    .we    (accept),
    .addr  (col),
    .wdata (pixel_in),
    .rdata (lb0Data)
  );

  // lb1 is fed from the old lb0 entry, so each column shifts down one row per accept.
  line_ram #(
    .DEPTH (IMG_W),
    .WIDTH (DATA_W)
  ) lb1 (
    .clock (clock),
    .we    (accept),
    .addr  (col),
    .wdata (lb0Data),
    .rdata (lb1Data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      a          <= '0;
      b          <= '0;
      c          <= '0;
      out_col    <= '0;
      out_row    <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (Enable) begin
        a          <= lb1Data;
        b          <= lb0Data;
        c          <= pixel_in;
        out_col    <= col;
        out_row    <= row;
        // Rows 0 and 1 would pair with stale or missing lines, so they stay silent.
        out_valid  <= (row >= RW'(2));
        frame_done <= lastRow && lastCol;
        if (lastCol) begin
          col <= '0;
          row <= lastRow ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_line_buffer3.sv
// Directed bench for line_buffer3: a 4x4 instance for the main scenarios and a
// 3x3 instance for the smallest legal frame.
module tb_line_buffer3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       Enable = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic [7:0] a, b, c;
  logic       out_valid, frame_done;
  logic [1:0] out_col, out_row;

  logic       en3 = 1'b0;
  logic [7:0] pix3 = 8'h00;
  logic [7:0] a3, b3, c3;
  logic       ov3, fd3;
  logic [1:0] oc3, or3;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  line_buffer3 #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .Enable     (Enable),
    .pixel_in   (pixel_in),
    .a          (a),
    .b          (b),
    .c          (c),
    .out_valid  (out_valid),
    .out_col    (out_col),
    .out_row    (out_row),
    .frame_done (frame_done)
  );

  line_buffer3 #(.DATA_W(8), .IMG_W(3), .IMG_H(3)) dut3 (
    .clock      (clock),
    .reset      (reset),
    .Enable     (en3),
    .pixel_in   (pix3),
    .a          (a3),
    .b          (b3),
    .c          (c3),
    .out_valid  (ov3),
    .out_col    (oc3),
    .out_row    (or3),
    .frame_done (fd3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the 4x4 instance, then settle just past the edge.
  task automatic applyStimulus(input logic en, input logic [7:0] pix);
    Enable   = en;
    pixel_in = pix;
    @(posedge clock);
    #1;
    Enable = 1'b0;
  endtask

  // One full 4x4 frame with pixel = base + row*16 + col, optionally with an idle
  // cycle after every accept; every cycle's outputs are checked.
  task automatic sendFrame(input logic [7:0] base, input bit gapped, input string name);
    int validCount = 0;
    logic [7:0] lastC;
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        lastC = 8'(base + r * 16 + col);
        applyStimulus(1'b1, lastC);
        if (out_valid) validCount++;
        checkOutput({name, "_valid"}, out_valid, (r >= 2));
        checkOutput({name, "_done"}, frame_done, (r == 3 && col == 3));
        checkOutput({name, "_c"}, c, lastC);
        if (r >= 2) begin
          checkOutput({name, "_a"}, a, 8'(base + (r - 2) * 16 + col));
          checkOutput({name, "_b"}, b, 8'(base + (r - 1) * 16 + col));
          checkOutput({name, "_row"}, out_row, r);
          checkOutput({name, "_col"}, out_col, col);
        end
        if (gapped) begin
          applyStimulus(1'b0, 8'hEE);
          checkOutput({name, "_gapvalid"}, out_valid, 0);
          checkOutput({name, "_gapdone"}, frame_done, 0);
          checkOutput({name, "_gapc"}, c, lastC);
          checkOutput({name, "_gapcol"}, out_col, col);
        end
      end
    end
    checkOutput({name, "_count"}, validCount, 8);
  endtask

  initial begin
    // Reset held two cycles, with a pixel offered during it that must be dropped.
    reset = 1'b1;
    @(posedge clock);
    Enable = 1'b1;
    pixel_in = 8'h55;
    @(posedge clock);
    #1;
    Enable = 1'b0;
    checkOutput("rst_a", a, 8'h00);
    checkOutput("rst_b", b, 8'h00);
    checkOutput("rst_c", c, 8'h00);
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_done", frame_done, 0);
    checkOutput("rst3_valid", ov3, 0);
    reset = 1'b0;

    $display("[TB] ramp frame");
    sendFrame(8'h00, 1'b0, "ramp");
    applyStimulus(1'b0, 8'h00);
    checkOutput("idle_done", frame_done, 0);
    checkOutput("idle_a_hold", a, 8'h13);

    $display("[TB] gapped frame");
    sendFrame(8'h00, 1'b1, "gap");

    $display("[TB] back-to-back frames");
    sendFrame(8'h00, 1'b0, "b2b1");
    sendFrame(8'h80, 1'b0, "b2b2");

    $display("[TB] mid-frame reset");
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 8'(8'h40 + k));
    Enable = 1'b1;
    pixel_in = 8'h77;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    Enable = 1'b0;
    checkOutput("mrst_valid", out_valid, 0);
    checkOutput("mrst_c", c, 8'h00);
    sendFrame(8'h00, 1'b0, "mrst");

    $display("[TB] 3x3 all-ones frame");
    for (int k = 0; k < 9; k++) begin
      en3  = 1'b1;
      pix3 = 8'hFF;
      @(posedge clock);
      #1;
      en3 = 1'b0;
      checkOutput("x_valid", ov3, (k / 3 >= 2));
      checkOutput("x_done", fd3, (k == 8));
      if (k / 3 >= 2) begin
        checkOutput("x_a", a3, 8'hFF);
        checkOutput("x_b", b3, 8'hFF);
        checkOutput("x_c", c3, 8'hFF);
        checkOutput("x_col", oc3, k % 3);
        checkOutput("x_row", or3, 2);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
